// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and types used by the digest output streamer.
package sha256_pkg;

  localparam int SHA256_DIGEST_W = 256;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } digest_tx_state_t;

  function automatic bit out_w_legal(input int unsigned w);
    return (w == 32) || (w == 64) || (w == 128);
  endfunction

endpackage

// File: rtl/sha256_digest_tx.sv
// Streams a captured 256-bit SHA-256 digest out as OUT_W-bit beats, MS beat first,
// with one pending slot so a digest finishing mid-transmission is not lost.
module sha256_digest_tx
  import sha256_pkg::*;
#(
  parameter int  OUT_W     = 32,
  localparam int NUM_BEATS = SHA256_DIGEST_W / OUT_W,
  localparam int IDX_W     = $clog2(NUM_BEATS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       digest_valid_i,
  input  logic [SHA256_DIGEST_W-1:0] digest_i,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic [OUT_W-1:0]           tx_data_o,
  output logic                       tx_last_o,
  output logic [IDX_W-1:0]           tx_idx_o,
  output logic                       busy_o,
  output logic                       drop_o
);

  if (!out_w_legal(OUT_W)) begin : g_bad_out_w
    $error("sha256_digest_tx: OUT_W must be 32, 64 or 128");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  digest_tx_state_t             state_q, state_d;
  logic [SHA256_DIGEST_W-1:0]   active_q, active_d;
  logic [SHA256_DIGEST_W-1:0]   pend_q, pend_d;
  logic                         pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         drop_q, drop_d;
  logic                         hs, last_hs;

  assign hs      = (state_q == SEND) && tx_ready_i;
  assign last_hs = hs && (idx_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    idx_d        = idx_q;
    drop_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (digest_valid_i) begin
          active_d = digest_i;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          active_d = active_q << OUT_W;
          idx_d    = idx_q + IDX_W'(1);
        end
        // Last beat frees the active slot, so a coincident digest is never dropped.
        if (last_hs) begin
          idx_d = '0;
          if (pend_valid_q) begin
            active_d     = pend_q;
            pend_valid_d = digest_valid_i;
            if (digest_valid_i) pend_d = digest_i;
          end else if (digest_valid_i) begin
            active_d = digest_i;
          end else begin
            state_d = IDLE;
          end
        end else if (digest_valid_i) begin
          if (!pend_valid_q) begin
            pend_d       = digest_i;
            pend_valid_d = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      active_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      idx_q        <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      idx_q        <= idx_d;
      drop_q       <= drop_d;
    end
  end

  assign tx_valid_o = (state_q == SEND);
  assign tx_data_o  = active_q[SHA256_DIGEST_W-1 -: OUT_W];
  assign tx_idx_o   = idx_q;
  assign tx_last_o  = tx_valid_o && (idx_q == LAST_IDX);
  assign busy_o     = (state_q == SEND) || pend_valid_q;
  assign drop_o     = drop_q;

endmodule

// File: tb/tb_sha256_digest_tx.sv
// Self-checking bench: a digest-FIFO reference model (depth 2, slot freed on the
// final beat) predicts every output of the OUT_W=32 instance each cycle.
module tb_sha256_digest_tx;

  localparam logic [255:0] ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk, rst;
  logic         dv, rdy, valid, last, busy, drop;
  logic [255:0] dig;
  logic [31:0]  data;
  logic [2:0]   idx;

  logic         dv_w, rdy_w, valid_w, last_w, busy_w, drop_w;
  logic [255:0] dig_w;
  logic [127:0] data_w;
  logic [0:0]   idx_w;

  sha256_digest_tx #(.OUT_W(32)) dut (
    .clk(clk), .rst(rst), .digest_valid_i(dv), .digest_i(dig),
    .tx_valid_o(valid), .tx_ready_i(rdy), .tx_data_o(data), .tx_last_o(last),
    .tx_idx_o(idx), .busy_o(busy), .drop_o(drop)
  );

  sha256_digest_tx #(.OUT_W(128)) dut_w (
    .clk(clk), .rst(rst), .digest_valid_i(dv_w), .digest_i(dig_w),
    .tx_valid_o(valid_w), .tx_ready_i(rdy_w), .tx_data_o(data_w), .tx_last_o(last_w),
    .tx_idx_o(idx_w), .busy_o(busy_w), .drop_o(drop_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs = 0;
  int n_drop = 0;
  logic [31:0]  obs[$];
  logic [255:0] mq[$];   // model: queue of accepted digests, head is being sent
  int           mb = 0;  // model: beat index within head digest
  logic         mdrop = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic [255:0] d, input logic rd);
    logic [255:0] cur;
    logic         ev, hs;
    rst = r; dv = v; dig = d; rdy = rd;
    ev = (mq.size() > 0);
    chk("valid", valid, ev);
    chk("busy", busy, ev);
    chk("drop", drop, mdrop);
    chk("idx", idx, ev ? mb : 0);
    chk("last", last, ev && (mb == 7));
    if (ev) begin
      cur = mq[0];
      chk("data", data, cur[255 - mb*32 -: 32]);
    end
    if (drop) n_drop++;
    if (valid && rd && !r) begin
      n_hs++;
      obs.push_back(data);
      $display("beat idx=%0d data=%h last=%0b", idx, data, last);
    end
    @(posedge clk);
    hs = ev && rd;
    if (r) begin
      mq.delete();
      mb = 0;
      mdrop = 1'b0;
    end else begin
      mdrop = 1'b0;
      if (hs) begin
        if (mb == 7) begin
          void'(mq.pop_front());
          mb = 0;
        end else begin
          mb++;
        end
      end
      if (v) begin
        if (mq.size() < 2) mq.push_back(d);
        else mdrop = 1'b1;
      end
    end
    #1;
  endtask

  task automatic run_to_beat(input int target);
    int n;
    n = 0;
    while (!(mq.size() > 0 && mb == target) && n < 60) begin
      tick(0, 0, '0, 1);
      n++;
    end
    chk("beat_wait_timeout", (n < 60), 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() > 0 && n < 100) begin
      tick(0, 0, '0, 1);
      n++;
    end
    chk("drain_timeout", mq.size(), 0);
    tick(0, 0, '0, 1);
  endtask

  initial begin
    int hs0, dr0, base;
    rst = 1'b1; dv = 1'b0; dig = '0; rdy = 1'b0;
    dv_w = 1'b0; dig_w = '0; rdy_w = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data, 0);
    chk("rst_data_w", data_w, 0);
    chk("rst_valid_w", valid_w, 0);
    tick(0, 0, '0, 0);

    // OUT_W=128: two beats, MS half first
    dv_w = 1'b1; dig_w = ABC; rdy_w = 1'b1;
    @(posedge clk); #1;
    dv_w = 1'b0;
    chk("w128_valid0", valid_w, 1);
    chk("w128_beat0", data_w, ABC[255:128]);
    chk("w128_idx0", idx_w, 0);
    chk("w128_last0", last_w, 0);
    @(posedge clk); #1;
    chk("w128_beat1", data_w, ABC[127:0]);
    chk("w128_idx1", idx_w, 1);
    chk("w128_last1", last_w, 1);
    @(posedge clk); #1;
    chk("w128_valid_end", valid_w, 0);
    chk("w128_busy_end", busy_w, 0);

    // single digest, ready high
    hs0 = n_hs; base = obs.size();
    tick(0, 1, ABC, 1);
    drain();
    chk("single_beats", n_hs - hs0, 8);
    chk("single_beat7", obs[base+7], 32'hf20015ad);

    // backpressure 1,0,0 pattern
    hs0 = n_hs;
    tick(0, 1, ABC, 1);
    for (int i = 0; i < 60 && mq.size() > 0; i++) tick(0, 0, '0, (i % 3) == 0);
    chk("bp_beats", n_hs - hs0, 8);

    // back-to-back, second digest at beat 3
    hs0 = n_hs; base = obs.size();
    tick(0, 1, ABC, 1);
    run_to_beat(3);
    tick(0, 1, EMPTY, 1);
    drain();
    chk("b2b_beats", n_hs - hs0, 16);
    chk("b2b_beat8", obs[base+8], 32'he3b0c442);

    // overflow: three pulses with ready low
    dr0 = n_drop; hs0 = n_hs;
    tick(0, 1, ABC, 0);
    tick(0, 1, EMPTY, 0);
    tick(0, 1, ~ABC, 0);
    tick(0, 0, '0, 0);
    drain();
    chk("ovf_drops", n_drop - dr0, 1);
    chk("ovf_beats", n_hs - hs0, 16);

    // coincident with last handshake, pending empty then full
    dr0 = n_drop; hs0 = n_hs;
    tick(0, 1, ABC, 1);
    run_to_beat(7);
    tick(0, 1, EMPTY, 1);
    drain();
    tick(0, 1, ABC, 1);
    tick(0, 1, EMPTY, 1);
    run_to_beat(7);
    tick(0, 1, ~EMPTY, 1);
    drain();
    chk("coinc_drops", n_drop - dr0, 0);
    chk("coinc_beats", n_hs - hs0, 40);

    // reset at beat 4
    tick(0, 1, ABC, 1);
    tick(0, 1, EMPTY, 0);
    run_to_beat(4);
    tick(1, 0, '0, 1);
    chk("midrst_data", data, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, '0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      tick(0, $urandom_range(0, 5) == 0,
           {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()},
           $urandom_range(0, 2) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_digest_tx.md
# sha256_digest_tx

Output-side streamer for the SHA-256 datapath. It captures the 256-bit digest when the core signals completion and transmits it to the host as fixed-width beats over a valid/ready handshake. It has one pending-digest slot, so a second digest completing during transmission is not lost. It sits between the SHA-256 top level (`hash`/`done`) and the host read interface, mirroring the 128-bit input path into the preprocessor.

## Interface
- `OUT_W`, default 32: beat width in bits; legal values are 32, 64 and 128.
- `NUM_BEATS`, derived as 256/OUT_W: beats per digest. Not overridable.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `digest_valid_i`, input, 1: one-cycle pulse, driven by the core `done`.
- `digest_i`, input, 256: digest; H0 is in [255:224]. Sampled only when `digest_valid_i` is 1.
- `tx_valid_o`, output, 1: beat available.
- `tx_ready_i`, input, 1: host accepts the beat.
- `tx_data_o`, output, OUT_W: beat data.
- `tx_last_o`, output, 1: marks the final beat of a digest.
- `tx_idx_o`, output, $clog2(NUM_BEATS): beat index, 0 first.
- `busy_o`, output, 1: active slot or pending slot occupied.
- `drop_o`, output, 1: one-cycle pulse when an incoming digest is discarded.

## Operation
- Storage is an active shift register (256 bits) plus a pending register (256 bits with a valid flag).
- States:
  - IDLE: active slot empty.
  - SEND: active slot holds a digest.
- IDLE to SEND: on `digest_valid_i`, load `digest_i` into the active slot and set the beat index to 0.
- Beat order is most-significant first.
  - Beat k is `digest_i[255-k*OUT_W -: OUT_W]`.
  - For OUT_W=32, beat 0 is H0 and beat 7 is H7.
  - No byte swapping.
- A beat transfers on `tx_valid_o && tx_ready_i`. On transfer, the active register shifts left by OUT_W and the index increments.
- `tx_last_o` is 1 exactly when `tx_idx_o == NUM_BEATS-1` and `tx_valid_o` is 1.
- Handshake on the last beat, in priority order:
  - If the pending slot is full, move pending into active, clear pending, reset the index to 0 and stay in SEND.
  - Else if `digest_valid_i` is 1 in the same cycle, load `digest_i` directly into active and stay in SEND.
  - Otherwise go to IDLE.
- `digest_valid_i` while in SEND, not on the last handshake:
  - Pending slot empty: store the digest in pending.
  - Pending slot full: discard the digest and pulse `drop_o` in the next cycle. Existing contents are untouched.
- `digest_valid_i` coinciding with the last handshake while pending is full: pending moves to active and the new digest goes to pending. No drop.
- `digest_valid_i` in IDLE: load directly into active. Pending stays empty.
- `busy_o` = (state == SEND) | pending_valid.

## Timing
- Reset values: `tx_valid_o`, `tx_data_o`, `tx_last_o`, `tx_idx_o`, `busy_o` and `drop_o` are all 0. State is IDLE and pending_valid is 0.
- Reset mid-transfer aborts immediately. Both slots are cleared; no partial beats after reset.
- Latency: `digest_valid_i` at edge N gives `tx_valid_o` = 1 with beat 0 at cycle N+1.
- With `tx_ready_i` held at 1, a digest drains in NUM_BEATS cycles.
- Back-to-back digests have zero bubble cycles.
- While `tx_valid_o && !tx_ready_i`, `tx_data_o`, `tx_idx_o` and `tx_last_o` hold stable.
- `tx_valid_o` never deasserts without a handshake, except on reset.
- `tx_valid_o` does not depend combinationally on `tx_ready_i`. All outputs are registered or decoded from registers only.

## Structure
- `sha256_pkg` holds:
  - `SHA256_DIGEST_W` = 256.
  - The `digest_tx_state_t` enum (IDLE, SEND).
  - The legal-OUT_W check function.
- Elaboration-time assertion in the module: OUT_W must be in {32, 64, 128}.
- Single flat module; no sub-module is warranted. The pending slot is one register plus a flag.

## Test plan
- Single digest, ready held high:
  - Stimulus: OUT_W=32, digest for "abc" = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - Required: beats in that order, `tx_idx_o` 0 to 7, `tx_last_o` only on f20015ad, `busy_o` low in the cycle after the last beat.
- Backpressure:
  - Stimulus: same digest; `tx_ready_i` toggles 1,0,0,1,...
  - Required: data and index stable while stalled; exactly 8 transfers.
- Back-to-back digests:
  - Stimulus: "abc" digest, then the empty-string digest (e3b0c442...7852b855) pulsed at beat 3.
  - Required: 16 contiguous beats, no bubble; beat 8 = e3b0c442.
- Overflow:
  - Stimulus: three digests pulsed on consecutive cycles while ready is low.
  - Required: `drop_o` pulses once, for the third digest; the first two are delivered intact.
- Coincident events:
  - Stimulus: new digest pulsed on the last handshake, with the pending slot both empty and full.
  - Required: no drop; no gap.
- OUT_W=128 and reset:
  - Stimulus: OUT_W=128 with the "abc" digest; also assert `rst` at beat 4 of an OUT_W=32 transfer.
  - Required: OUT_W=128 gives 2 beats, ba7816bf8f01cfea414140de5dae2223 then b00361a3...f20015ad. After the mid-transfer reset, all outputs read 0 in the next cycle and no residual beats appear.
